// File: rtl/qic117_status_decoder.sv
// qic117_status_decoder
// Host-side receiver for QIC-117 time-encoded status returned on TRK0.
// Once armed, it measures each TRK0 low pulse in microseconds, classifies it
// as a 0 or 1 bit, shifts the bits in MSB-first and pulses data_valid_o when
// the requested number of bits has arrived.
// Optional feature: define QIC117_DEC_FILTER_EN to add a 16-sample level
// filter after the synchronizer.
// The clock must be at least 2 MHz so that one microsecond spans two or more clocks.

module qic117_status_decoder #(
    parameter int CLK_FREQ_HZ = 200_000_000,
    parameter int GLITCH_US   = 250,
    parameter int THRESH_US   = 1000,
    parameter int MAX_LOW_US  = 2500,
    parameter int TIMEOUT_US  = 5000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable_i,
    input  logic        arm_i,
    input  logic [3:0]  nbits_i,
    input  logic        trk0_in_i,
    output logic [7:0]  data_out_o,
    output logic        data_valid_o,
    output logic        error_o,
    output logic [1:0]  err_code_o,
    output logic        busy_o,
    output logic [3:0]  bits_rcvd_o,
    output logic [12:0] last_width_us_o
);

    localparam int DIV = CLK_FREQ_HZ / 1_000_000;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TICK = PW'(DIV - 2);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [12:0]   US_SAT     = 13'h1FFF;
    localparam logic [12:0]   GLITCH_W   = 13'(GLITCH_US);
    localparam logic [12:0]   THRESH_W   = 13'(THRESH_US);
    localparam logic [12:0]   MAX_LOW_W  = 13'(MAX_LOW_US);
    localparam logic [12:0]   TIMEOUT_W  = 13'(TIMEOUT_US);

    typedef enum logic [2:0] {IDLE, WAIT_LOW, MEAS_LOW, DONE, ERR} state_t;

    state_t        state_q;
    logic          sync1_q, sync2_q, trk0Prev_q, trk0S;
    logic [PW-1:0] presc_q;
    logic [12:0]   usCount_q, lastWidth_q;
    logic [3:0]    nbits_q, bitsRcvd_q;
    logic [7:0]    shift_q, dataOut_q;
    logic          dataValid_q, error_q, busy_q;
    logic [1:0]    errCode_q;

    logic          rise, fall, edgeSeen, armAccept, tooLong, glitchRise;
    logic [3:0]    nbitsEff_d, bitsRcvd_d;
    logic [7:0]    shift_d;

    // Two-flop synchronizer for the asynchronous TRK0 line (idle level is high)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= trk0_in_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef QIC117_DEC_FILTER_EN
    logic       filt_q;
    logic [3:0] filtCnt_q;

    // Accept a new level only after 16 consecutive samples that disagree with the current one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt_q    <= 1'b1;
            filtCnt_q <= 4'd0;
        end else if (sync2_q == filt_q) begin
            filtCnt_q <= 4'd0;
        end else if (filtCnt_q == 4'd15) begin
            filt_q    <= sync2_q;
            filtCnt_q <= 4'd0;
        end else begin
            filtCnt_q <= filtCnt_q + 4'd1;
        end
    end

    assign trk0S = filt_q;
`else
    assign trk0S = sync2_q;
`endif

    // Previous line level for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) trk0Prev_q <= 1'b1;
        else          trk0Prev_q <= trk0S;
    end

    // Edge, arm and width-classification decodes shared by the counter and the FSM
    always_comb begin
        rise       = trk0S & ~trk0Prev_q;
        fall       = ~trk0S & trk0Prev_q;
        edgeSeen   = rise | fall;
        armAccept  = arm_i & enable_i & (state_q == IDLE) & trk0S;
        tooLong    = (state_q == MEAS_LOW) && (usCount_q > MAX_LOW_W);
        glitchRise = (state_q == MEAS_LOW) && !tooLong && rise && (usCount_q < GLITCH_W);
        nbitsEff_d = ((nbits_i == 4'd0) || (nbits_i > 4'd8)) ? 4'd8 : nbits_i;
        bitsRcvd_d = bitsRcvd_q + 4'd1;
        shift_d    = {shift_q[6:0], (usCount_q >= THRESH_W)};
    end

    // Microsecond counter: restarts on every edge except a rejected glitch rise, so high
    // time keeps accumulating toward the timeout. The prescaler phase makes a low of exactly
    // N us read as N when the rising edge is acted on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            usCount_q <= 13'd0;
        end else if (armAccept) begin
            presc_q   <= '0;
            usCount_q <= 13'd0;
        end else if (edgeSeen) begin
            presc_q <= '0;
            if (!glitchRise) usCount_q <= 13'd0;
        end else begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
            if ((presc_q == PRESC_TICK) && (usCount_q != US_SAT)) usCount_q <= usCount_q + 13'd1;
        end
    end

    // Reception FSM; data_valid/error are registered on the transition into DONE/ERR so
    // they appear one clock after the synchronized edge, and those states just return to IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            nbits_q     <= 4'd0;
            bitsRcvd_q  <= 4'd0;
            shift_q     <= 8'd0;
            dataOut_q   <= 8'd0;
            dataValid_q <= 1'b0;
            error_q     <= 1'b0;
            errCode_q   <= 2'd0;
            busy_q      <= 1'b0;
            lastWidth_q <= 13'd0;
        end else begin
            dataValid_q <= 1'b0;
            error_q     <= 1'b0;
            if (!enable_i) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (arm_i) begin
                            if (trk0S) begin
                                nbits_q    <= nbitsEff_d;
                                shift_q    <= 8'd0;
                                bitsRcvd_q <= 4'd0;
                                errCode_q  <= 2'd0;
                                busy_q     <= 1'b1;
                                state_q    <= WAIT_LOW;
                            end else begin
                                error_q   <= 1'b1;
                                errCode_q <= 2'd3;
                            end
                        end
                    end
                    WAIT_LOW: begin
                        if (fall) begin
                            state_q <= MEAS_LOW;
                        end else if (trk0S && (usCount_q > TIMEOUT_W)) begin
                            error_q   <= 1'b1;
                            errCode_q <= 2'd2;
                            busy_q    <= 1'b0;
                            state_q   <= ERR;
                        end
                    end
                    MEAS_LOW: begin
                        if (tooLong) begin
                            error_q   <= 1'b1;
                            errCode_q <= 2'd1;
                            busy_q    <= 1'b0;
                            state_q   <= ERR;
                        end else if (rise) begin
                            if (glitchRise) begin
                                state_q <= WAIT_LOW;
                            end else begin
                                shift_q     <= shift_d;
                                bitsRcvd_q  <= bitsRcvd_d;
                                lastWidth_q <= usCount_q;
                                if (bitsRcvd_d == nbits_q) begin
                                    dataOut_q   <= shift_d;
                                    dataValid_q <= 1'b1;
                                    busy_q      <= 1'b0;
                                    state_q     <= DONE;
                                end else begin
                                    state_q <= WAIT_LOW;
                                end
                            end
                        end
                    end
                    DONE:    state_q <= IDLE;
                    ERR:     state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out_o      = dataOut_q;
    assign data_valid_o    = dataValid_q;
    assign error_o         = error_q;
    assign err_code_o      = errCode_q;
    assign busy_o          = busy_q;
    assign bits_rcvd_o     = bitsRcvd_q;
    assign last_width_us_o = lastWidth_q;

endmodule
